// File: rtl/md_unit_ctrl_if.sv
// md_unit_ctrl_if
//   Execute-stage <-> mul/div controller bundle.
//   master (execute stage): req_valid, req_op, src1, src2, flush -> ; <- req_ready, busy, div_done, hi, lo
//   slave  (md_unit_ctrl) : the mirror image.
//   W: operand / HI / LO width.
interface md_unit_ctrl_if #(
   parameter int W = 32
);
   logic         req_valid;
   logic         req_ready;
   logic [2:0]   req_op;
   logic [W-1:0] src1;
   logic [W-1:0] src2;
   logic         flush;
   logic         busy;
   logic         div_done;
   logic [W-1:0] hi;
   logic [W-1:0] lo;

   modport master (
      output req_valid, req_op, src1, src2, flush,
      input  req_ready, busy, div_done, hi, lo
   );

   modport slave (
      input  req_valid, req_op, src1, src2, flush,
      output req_ready, busy, div_done, hi, lo
   );
endinterface

// File: rtl/md_unit_ctrl.sv
// md_unit_ctrl
//   Owns HI/LO for the execute stage. MULT/MULTU/MTHI/MTLO update HI/LO on the
//   accept edge with no stall. DIV/DIVU share one iterative restoring divider
//   working on magnitudes, followed by a single sign-fixup/commit cycle.
//   Ports:
//     clk, resetn : clock, asynchronous active-low reset
//     bus (slave) : req_valid/req_ready/req_op/src1/src2 request handshake,
//                   flush (cancels pending divide, blocks accept),
//                   busy, div_done (commit pulse), hi, lo
//   Parameters: W operand width, CNT_W iteration counter width (2^CNT_W >= W).
//   Optional build macro: MD_DIV0_FAST_EN -- a divide by zero skips the
//   iteration phase and goes straight to the fixup/commit cycle. Results are
//   identical either way; only the busy duration changes.
module md_unit_ctrl #(
   parameter int W     = 32,
   parameter int CNT_W = 5
) (
   input  logic          clk,
   input  logic          resetn,
   md_unit_ctrl_if.slave bus
);
   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   typedef enum logic [1:0] {S_IDLE, S_DIV, S_FIX} state_t;

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt;
   logic [W-1:0]     quo;      // dividend magnitude, shifted out as quotient bits shift in
   logic [W-1:0]     rem;      // partial remainder
   logic [W-1:0]     dvs;      // divisor magnitude
   logic [W-1:0]     src1_q;   // original dividend, returned as HI on divide-by-zero
   logic             neg_q, neg_r, div0;
   logic [W-1:0]     hi_q, lo_q;

   logic             ready_c, busy_c, done_c, commit;
   logic             accept, is_div;

   //---------------------------------------------------------------- control
   assign is_div = (bus.req_op == OP_DIV) || (bus.req_op == OP_DIVU);
   assign accept = bus.req_valid && ready_c && !bus.flush;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= S_IDLE;
      else         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      ready_c  = 1'b0;
      busy_c   = 1'b0;
      done_c   = 1'b0;
      commit   = 1'b0;
      unique case (state)
         S_IDLE: begin
            ready_c = 1'b1;
            if (accept && is_div) begin
`ifdef MD_DIV0_FAST_EN
               state_nx = (bus.src2 == '0) ? S_FIX : S_DIV;
`else
               state_nx = S_DIV;
`endif
            end
         end
         S_DIV: begin
            busy_c = 1'b1;
            if (cnt == '0) state_nx = S_FIX;
         end
         S_FIX: begin
            busy_c   = 1'b1;
            done_c   = !bus.flush;
            commit   = !bus.flush;
            state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
      // flush wins over everything: back to IDLE, nothing committed
      if (bus.flush) state_nx = S_IDLE;
   end

   assign bus.req_ready = ready_c;
   assign bus.busy      = busy_c;
   assign bus.div_done  = done_c;
   assign bus.hi        = hi_q;
   assign bus.lo        = lo_q;

   //---------------------------------------------------------------- operand prep
   logic         sgn, s1_neg, s2_neg, mx;
   logic [W-1:0] mag1, mag2;
   logic [2*W-1:0] ma, mb, prod;

   assign sgn    = (bus.req_op == OP_DIV);
   assign s1_neg = sgn && bus.src1[W-1];
   assign s2_neg = sgn && bus.src2[W-1];
   assign mag1   = s1_neg ? -bus.src1 : bus.src1;
   assign mag2   = s2_neg ? -bus.src2 : bus.src2;

   // Low 2W bits of the (W+1)x(W+1) extended product equal those of a 2W x 2W
   // product of the same operands extended to 2W bits.
   assign mx   = (bus.req_op == OP_MULT);
   assign ma   = {{W{mx && bus.src1[W-1]}}, bus.src1};
   assign mb   = {{W{mx && bus.src2[W-1]}}, bus.src2};
   assign prod = ma * mb;

   //---------------------------------------------------------------- restoring step
   logic [W:0]   rem_sh, trial;
   logic [W-1:0] rem_nx, quo_nx;

   assign rem_sh = {rem, quo[W-1]};
   assign trial  = rem_sh - {1'b0, dvs};
   // trial[W] set means the subtract borrowed: keep shifted remainder, quotient bit 0
   assign rem_nx = trial[W] ? rem_sh[W-1:0] : trial[W-1:0];
   assign quo_nx = {quo[W-2:0], ~trial[W]};

   logic [W-1:0] q_fix, r_fix;
   assign q_fix = div0 ? '1     : (neg_q ? -quo : quo);
   assign r_fix = div0 ? src1_q : (neg_r ? -rem : rem);

   //---------------------------------------------------------------- datapath
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt    <= '0;
         quo    <= '0;
         rem    <= '0;
         dvs    <= '0;
         src1_q <= '0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         div0   <= 1'b0;
         hi_q   <= '0;
         lo_q   <= '0;
      end else begin
         if (accept) begin
            unique case (bus.req_op)
               OP_MULT, OP_MULTU: {hi_q, lo_q} <= prod;
               OP_MTHI:           hi_q <= bus.src1;
               OP_MTLO:           lo_q <= bus.src1;
               OP_DIV, OP_DIVU: begin
                  quo    <= mag1;
                  dvs    <= mag2;
                  rem    <= '0;
                  src1_q <= bus.src1;
                  neg_q  <= s1_neg ^ s2_neg;
                  neg_r  <= s1_neg;
                  div0   <= (bus.src2 == '0);
                  cnt    <= CNT_W'(W - 1);
               end
               default: ;
            endcase
         end
         if (state == S_DIV) begin
            rem <= rem_nx;
            quo <= quo_nx;
            if (cnt != '0) cnt <= cnt - 1'b1;
         end
         if (commit) begin
            lo_q <= q_fix;
            hi_q <= r_fix;
         end
      end
   end
endmodule

// File: tb/tb_md_unit_ctrl.sv
// tb_md_unit_ctrl
//   Directed test-plan cases plus randomized op stream against a reference
//   model of HI/LO built from plain 64-bit arithmetic.
module tb_md_unit_ctrl;
   localparam int W = 32;

   logic clk = 1'b0;
   logic resetn;
   int   n_chk = 0;
   int   n_err = 0;
   logic [31:0] m_hi, m_lo;

   always #5 clk = ~clk;

   md_unit_ctrl_if #(.W(W)) bus ();

   md_unit_ctrl #(.W(W), .CNT_W(5)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // HI/LO after an op, from the arithmetic definition of each instruction
   task automatic ref_step(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           inout logic [31:0] h, inout logic [31:0] l);
      longint      sa, sb, p;
      logic [63:0] up;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         3'd0: begin p = sa * sb; {h, l} = p; end
         3'd1: begin up = {32'd0, a} * {32'd0, b}; {h, l} = up; end
         3'd2: if (b == 0) begin l = '1; h = a; end
               else begin p = sa / sb; l = p[31:0]; p = sa % sb; h = p[31:0]; end
         3'd3: if (b == 0) begin l = '1; h = a; end
               else begin l = a / b; h = a % b; end
         3'd4: h = a;
         3'd5: l = a;
         default: ;
      endcase
   endtask

   // Issue one op from IDLE; fl_at >= 0 flushes a divide fl_at cycles after accept.
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int fl_at);
      logic [31:0] eh, el;
      int k, exp_k;
      eh = m_hi;
      el = m_lo;
      ref_step(op, a, b, eh, el);
      exp_k = W;
`ifdef MD_DIV0_FAST_EN
      if (b == 0) exp_k = 0;
`endif
      chk("ready_idle", bus.req_ready, 1);
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.src1      = a;
      bus.src2      = b;
      tick;
      bus.req_valid = 1'b0;
      bus.src1      = $urandom;   // must not matter after accept
      bus.src2      = $urandom;
      if (op != 3'd2 && op != 3'd3) begin
         chk("ready_nodiv", bus.req_ready, 1);
         chk("hi_nodiv", bus.hi, eh);
         chk("lo_nodiv", bus.lo, el);
         m_hi = eh;
         m_lo = el;
      end else begin
         chk("busy_acc", bus.busy, 1);
         k = 0;
         while (k != fl_at && !bus.div_done && k <= W + 3) begin
            tick;
            k++;
         end
         if (k == fl_at) begin
            bus.flush = 1'b1;
            #1;
            chk("done_flushed", bus.div_done, 0);
            tick;
            bus.flush = 1'b0;
            chk("busy_flush", bus.busy, 0);
            chk("ready_flush", bus.req_ready, 1);
            chk("hi_flush", bus.hi, m_hi);
            chk("lo_flush", bus.lo, m_lo);
         end else begin
            chk("div_lat", k, exp_k);
            chk("done_hi", bus.div_done, 1);
            tick;
            chk("done_pulse", bus.div_done, 0);
            chk("busy_end", bus.busy, 0);
            chk("hi_div", bus.hi, eh);
            chk("lo_div", bus.lo, el);
            m_hi = eh;
            m_lo = el;
         end
      end
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'h0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int k;
      logic [2:0] op;
      resetn        = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_op    = 3'd0;
      bus.src1      = '0;
      bus.src2      = '0;
      bus.flush     = 1'b0;
      m_hi          = '0;
      m_lo          = '0;
      #3;
      chk("rst_hi", bus.hi, 0);
      chk("rst_lo", bus.lo, 0);
      chk("rst_ready", bus.req_ready, 1);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.div_done, 0);
      #4 resetn = 1'b1;
      tick;

      // multiply
      run_op(3'd0, 32'hFFFF_FFFF, 32'd2, -1);
      chk("tp_mult_hi", bus.hi, 32'hFFFF_FFFF);
      chk("tp_mult_lo", bus.lo, 32'hFFFF_FFFE);
      run_op(3'd1, 32'hFFFF_FFFF, 32'd2, -1);
      chk("tp_multu_hi", bus.hi, 32'h0000_0001);
      chk("tp_multu_lo", bus.lo, 32'hFFFF_FFFE);

      // divide corners
      run_op(3'd2, 32'hFFFF_FFF9, 32'd2, -1);
      chk("tp_div_lo", bus.lo, 32'hFFFF_FFFD);
      chk("tp_div_hi", bus.hi, 32'hFFFF_FFFF);
      run_op(3'd3, 32'hFFFF_FFFF, 32'h10, -1);
      chk("tp_divu_lo", bus.lo, 32'h0FFF_FFFF);
      chk("tp_divu_hi", bus.hi, 32'h0000_000F);
      run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, -1);
      chk("tp_ovf_lo", bus.lo, 32'h8000_0000);
      chk("tp_ovf_hi", bus.hi, 32'h0);
      run_op(3'd3, 32'd5, 32'd0, -1);
      chk("tp_div0_lo", bus.lo, 32'hFFFF_FFFF);
      chk("tp_div0_hi", bus.hi, 32'd5);

      // flush mid-divide and in the commit cycle
      run_op(3'd4, 32'h1111, 32'd0, -1);
      run_op(3'd5, 32'h2222, 32'd0, -1);
      run_op(3'd2, 32'd100, 32'd7, 10);
      run_op(3'd2, 32'd100, 32'd7, W);
      chk("tp_flush_hi", bus.hi, 32'h1111);
      chk("tp_flush_lo", bus.lo, 32'h2222);

      // flush coincident with a request blocks the accept
      bus.req_valid = 1'b1;
      bus.req_op    = 3'd4;
      bus.src1      = 32'hDEAD_BEEF;
      bus.flush     = 1'b1;
      tick;
      bus.req_valid = 1'b0;
      bus.flush     = 1'b0;
      chk("flush_noacc", bus.hi, 32'h1111);

      // back-to-back: MTLO held valid across the divide
      bus.req_valid = 1'b1;
      bus.req_op    = 3'd3;
      bus.src1      = 32'd100;
      bus.src2      = 32'd7;
      tick;
      bus.req_op    = 3'd5;
      bus.src1      = 32'hABCD;
      k = 0;
      while (!bus.div_done && k <= W + 3) begin
         chk("b2b_hold", bus.lo, 32'h2222);
         tick;
         k++;
      end
      chk("b2b_lat", k, W);
      tick;
      chk("b2b_lo_div", bus.lo, 32'd14);
      chk("b2b_hi_div", bus.hi, 32'd2);
      tick;
      bus.req_valid = 1'b0;
      chk("b2b_lo_mtlo", bus.lo, 32'hABCD);
      chk("b2b_hi_mtlo", bus.hi, 32'd2);
      m_hi = 32'd2;
      m_lo = 32'hABCD;

      // async reset mid-divide
      bus.req_valid = 1'b1;
      bus.req_op    = 3'd2;
      bus.src1      = 32'd1000;
      bus.src2      = 32'd3;
      tick;
      bus.req_valid = 1'b0;
      repeat (5) tick;
      #2 resetn = 1'b0;
      #1;
      chk("arst_hi", bus.hi, 0);
      chk("arst_lo", bus.lo, 0);
      chk("arst_busy", bus.busy, 0);
      chk("arst_ready", bus.req_ready, 1);
      #2 resetn = 1'b1;
      m_hi = '0;
      m_lo = '0;
      tick;
      run_op(3'd3, 32'd9, 32'd3, -1);
      chk("tp_post_lo", bus.lo, 32'd3);
      chk("tp_post_hi", bus.hi, 32'd0);

      // randomized op stream
      for (int i = 0; i < 60; i++) begin
         op = 3'($urandom_range(0, 7));
         if ((op == 3'd2 || op == 3'd3) && $urandom_range(0, 7) == 0)
            run_op(op, pick(), pick(), $urandom_range(0, W));
         else
            run_op(op, pick(), pick(), -1);
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
